instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of the processor's control decoder; supplies one 8-bit instruction per clock on `instr`.
- Owns a small writable program memory, the program counter (PC) and a run/halt state machine.
- Program is loaded through a simple write port while idle or halted; a `start` pulse begins execution from address 0.
- Fetching stops after the HALT opcode (8'h13) has been issued; NOP (8'hFF) is presented whenever no valid instruction exists.

Parameters:
- DEPTH, 32, program memory depth in instructions; power of two, >= 2.
- ADDR_W, $clog2(DEPTH), PC and load-address width; derived, not overridden.
- CNT_W, 16, width of the fetched-instruction counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse: begin execution at address 0
- stall  input  1  hold current instruction and PC (downstream not ready)
- load_we  input  1  program-memory write strobe
- load_addr  input  ADDR_W  write address
- load_data  input  8  instruction to write
- load_ready  output  1  high when writes are accepted (IDLE or HALTED)
- instr  output  8  instruction to the decoder
- instr_valid  output  1  instr holds a fetched instruction
- pc  output  ADDR_W  address of the next fetch
- halted  output  1  HALT has been issued
- fetch_count  output  CNT_W  instructions issued since the last start; saturating

Behaviour:
- Clock port is `clk`; reset port is `rst`, synchronous and active-high.
- Reset values:
  - state = IDLE, pc = 0
  - instr = 8'hFF, instr_valid = 0
  - halted = 0, fetch_count = 0
  - Memory contents are not cleared by reset.
- States: IDLE, RUN, HALTED. load_ready = 1 in IDLE and HALTED, 0 in RUN.
- Program memory:
  - Synchronous write: when load_we && load_ready, mem[load_addr] <= load_data.
  - Combinational read at pc.
  - load_we in RUN is ignored; memory is left unchanged.
- IDLE:
  - Outputs hold their reset values.
  - start -> RUN with pc <= 0 and fetch_count <= 0.
- RUN, stall = 0, each cycle:
  - instr <= mem[pc], instr_valid <= 1.
  - pc <= (pc + 1) mod DEPTH; wraps from DEPTH-1 to 0.
  - fetch_count increments, saturating at all-ones.
  - Latency: `start` sampled at edge N; mem[0] appears on instr after edge N+1.
- RUN, stall = 1:
  - instr, instr_valid, pc and fetch_count all hold.
  - start is ignored.
- HALT detection (RUN, stall = 0, mem[pc] == 8'h13):
  - HALT is issued as a normal fetch: instr = 8'h13, valid = 1, fetch_count increments.
  - State -> HALTED and halted <= 1.
  - pc does not advance; it stays at the HALT address.
- HALTED:
  - On the first HALTED cycle edge: instr <= 8'hFF, instr_valid <= 0, so HALT is visible for exactly one cycle.
  - pc and fetch_count hold; writes are accepted.
  - start -> RUN with pc <= 0, halted <= 0, fetch_count <= 0.
- Simultaneous events:
  - start with load_we (IDLE/HALTED): the write commits at that edge and is visible to the first fetch.
  - start during RUN: ignored.
  - stall with HALT at pc: HALT is not taken until stall drops.
- rst mid-run: the next edge forces all reset values and aborts execution. Memory is preserved, so a following start re-runs the same program.

Decomposition:
- Shared package proc_pkg:
  - OP_HALT = 8'h13, OP_NOP = 8'hFF
  - fetch state enum {IDLE, RUN, HALTED}
  - The same package also holds the ALU opcode constants used by the decoder.
- Sub-module prog_mem:
  - Parameterised DEPTH × 8.
  - Synchronous write port, combinational read port.
  - The fetch FSM, PC and counter stay in instr_fetch.

Test Plan:
- Load mem[0..3] = 00, 01, 02, 13 while IDLE, then pulse start -> instr = 00, 01, 02, 13 on four consecutive cycles with valid = 1. Next cycle: instr = FF, valid = 0, halted = 1, pc = 3, fetch_count = 4.
- Same program with stall high for 2 cycles while instr = 01 -> instr stays 01 and pc stays 2 for those cycles; HALT arrives 2 cycles late; fetch_count = 4.
- DEPTH = 4, no HALT in memory (00, 01, 02, 03) -> pc sequence 1, 2, 3, 0, 1; instr repeats 00..03; valid stays 1.
- Attempt load_we during RUN (addr 1, data 13) -> load_ready = 0, mem[1] unchanged, execution continues. After HALT, the same write succeeds; a new start then halts at address 1.
- Assert rst during RUN at instr = 01 -> next cycle instr = FF, valid = 0, pc = 0, state IDLE. Then start -> program re-executes from 00 with memory intact.
- start and load_we (addr 0, data 0A) in the same IDLE cycle -> first issued instruction is 0A.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor definitions: fetch-stage opcodes and state encoding,
// plus the ALU opcode constants consumed by the control decoder.
package proc_pkg;

    localparam logic [7:0] OP_HALT = 8'h13;
    localparam logic [7:0] OP_NOP  = 8'hFF;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_XOR = 4'h4;
    localparam logic [3:0] ALU_SHL = 4'h5;
    localparam logic [3:0] ALU_SHR = 4'h6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/prog_mem.sv
// DEPTH x 8 program memory: synchronous write port, combinational read port.
// Contents are intentionally not reset.
module prog_mem #(
    parameter  int unsigned DEPTH  = 32,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns program memory, PC, run/halt FSM and a
// saturating count of instructions issued since the last start.
module instr_fetch
    import proc_pkg::*;
#(
    parameter  int unsigned DEPTH  = 32,
    localparam int unsigned ADDR_W = $clog2(DEPTH),
    parameter  int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    output logic              load_ready,
    output logic [7:0]        instr,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [CNT_W-1:0]  fetch_count
);

    fetch_state_t state;
    logic [7:0]   rd_data;

    assign load_ready = (state != RUN);

    prog_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (load_we && load_ready),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (pc),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            instr       <= OP_NOP;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        pc          <= '0;
                        fetch_count <= '0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        instr       <= rd_data;
                        instr_valid <= 1'b1;
                        if (fetch_count != '1) begin
                            fetch_count <= fetch_count + 1'b1;
                        end
                        // HALT is issued like any fetch but the PC stays parked on it
                        if (rd_data == OP_HALT) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            pc <= pc + 1'b1;
                        end
                    end
                end
                HALTED: begin
                    instr       <= OP_NOP;
                    instr_valid <= 1'b0;
                    if (start) begin
                        state       <= RUN;
                        pc          <= '0;
                        halted      <= 1'b0;
                        fetch_count <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed program scenarios followed by
// random traffic, checked against a behavioural fetch model.
module tb_instr_fetch;

    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          load_we = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [7:0]    load_data = '0;
    logic          load_ready;
    logic [7:0]    instr;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          halted;
    logic [CW-1:0] fetch_count;

    always #5 clk = ~clk;

    instr_fetch #(.DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stall       (stall),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    typedef struct {
        logic [7:0]    instr;
        logic          valid;
        logic [AW-1:0] pc;
        logic          halted;
        logic [CW-1:0] cnt;
        logic          ready;
    } snap_t;

    snap_t expq[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    cycle_no = 0;

    // Reference model: program image plus "running" / "finished" flags.
    int mmem[DEPTH];
    bit running = 0;
    bit done = 0;
    int mpc = 0;
    int mcnt = 0;
    int minstr = 8'hFF;
    bit mvalid = 0;

    task automatic cyc(input bit r, input bit s, input bit st, input bit we,
                       input int a, input int d);
        bit    was_running;
        int    op;
        snap_t e;
        @(negedge clk);
        rst = r; start = s; stall = st; load_we = we;
        load_addr = a[AW-1:0]; load_data = d[7:0];
        was_running = running;
        if (r) begin
            running = 0; done = 0; mpc = 0; mcnt = 0; minstr = 8'hFF; mvalid = 0;
        end else if (running) begin
            if (!st) begin
                op = mmem[mpc];
                minstr = op;
                mvalid = 1;
                mcnt = (mcnt == CMAX) ? CMAX : mcnt + 1;
                if (op == 8'h13) begin
                    running = 0;
                    done = 1;
                end else begin
                    mpc = (mpc + 1) % DEPTH;
                end
            end
        end else begin
            if (done) begin
                minstr = 8'hFF;
                mvalid = 0;
            end
            if (s) begin
                running = 1; done = 0; mpc = 0; mcnt = 0;
            end
        end
        if (we && !was_running) mmem[a % DEPTH] = d & 8'hFF;
        e.instr = minstr[7:0];
        e.valid = mvalid;
        e.pc = mpc[AW-1:0];
        e.halted = done;
        e.cnt = mcnt[CW-1:0];
        e.ready = !running;
        expq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    task automatic load(input int a, input int d);
        cyc(0, 0, 0, 1, a, d);
    endtask

    // Monitor: one expected snapshot per clock edge, sampled just after it.
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            cycle_no++;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                vectors++;
                if (instr !== e.instr || instr_valid !== e.valid || pc !== e.pc ||
                    halted !== e.halted || fetch_count !== e.cnt || load_ready !== e.ready) begin
                    miscompares++;
                    $display("FAIL cycle %0d outputs: got instr=%h valid=%b pc=%0d halted=%b cnt=%0d ready=%b, expected instr=%h valid=%b pc=%0d halted=%b cnt=%0d ready=%b",
                             cycle_no, instr, instr_valid, pc, halted, fetch_count, load_ready,
                             e.instr, e.valid, e.pc, e.halted, e.cnt, e.ready);
                end
            end
        end
    end

    initial begin
        int wait_cycles;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);

        // Basic program ending in HALT
        load(0, 8'h00); load(1, 8'h01); load(2, 8'h02); load(3, 8'h13);
        load(4, 8'h20); load(5, 8'h21); load(6, 8'h22); load(7, 8'h23);
        cyc(0, 1, 0, 0, 0, 0);
        idle(7);

        // Same program, stall two cycles while instr = 01
        cyc(0, 1, 0, 0, 0, 0);
        idle(2);
        cyc(0, 0, 1, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0);
        idle(6);

        // No HALT: PC wraps and the counter saturates; write during RUN ignored
        load(3, 8'h03);
        cyc(0, 1, 0, 0, 0, 0);
        idle(5);
        cyc(0, 0, 0, 1, 1, 8'h13);
        idle(14);
        cyc(1, 0, 0, 0, 0, 0);

        // Write accepted once idle; new program halts at address 1
        load(1, 8'h13);
        cyc(0, 1, 0, 0, 0, 0);
        idle(4);

        // Reset while instr = 01, then rerun from intact memory
        load(1, 8'h01); load(3, 8'h13);
        cyc(0, 1, 0, 0, 0, 0);
        idle(2);
        cyc(1, 0, 0, 0, 0, 0);
        idle(1);
        cyc(0, 1, 0, 0, 0, 0);
        idle(6);

        // start and write in the same idle cycle
        cyc(1, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 0, 8'h0A);
        idle(6);

        for (int i = 0; i < 400; i++) begin
            int d;
            d = ($urandom_range(5) == 0) ? 8'h13 : int'($urandom_range(255));
            cyc($urandom_range(59) == 0, $urandom_range(7) == 0, $urandom_range(3) == 0,
                $urandom_range(2) == 0, int'($urandom_range(DEPTH - 1)), d);
        end
        cyc(0, 0, 0, 0, 0, 0);

        wait_cycles = 0;
        while (expq.size() != 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(posedge clk);
        #2;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected snapshots left, required 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
